// File: rtl/multdiv_if.sv
// Operand, start and result bundle between the execute-stage control and the
// multi-cycle multiplier/divider.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv.sv
// Signed 32-bit multi-cycle multiplier / divider: 32 magnitude iterations,
// sign fix-up and exception detection on the edge that enters DONE.
module multdiv (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_count;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [64:0] r_acc;
    logic [31:0] r_result;
    logic        r_exception;
    logic        r_rdy;

    logic        w_start;
    logic        w_lastIter;
    logic        w_neg;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [33:0] w_mulSum;
    logic [64:0] w_mulNext;
    logic [64:0] w_mulProd;
    logic        w_mulExc;
    logic [32:0] w_divShift;
    logic [33:0] w_divDiff;
    logic [32:0] w_divRem;
    logic [64:0] w_divNext;
    logic [31:0] w_quot;
    logic        w_divSpecial;

    // 0x80000000 maps to unsigned 2^31, which still fits the 32-bit magnitude
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign w_start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_lastIter = ((r_state == MUL) || (r_state == DIV)) && (r_count == 6'd32);
    assign w_neg      = r_opA[31] ^ r_opB[31];
    assign w_magA     = mag32(r_opA);
    assign w_magB     = mag32(r_opB);

    // Multiply: upper 33 bits accumulate, multiplier bits retire from bit 0
    assign w_mulSum  = {1'b0, r_acc[64:32]} + {2'b00, (r_acc[0] ? w_magA : 32'd0)};
    assign w_mulNext = {w_mulSum, r_acc[31:1]};
    assign w_mulProd = w_neg ? (65'd0 - r_acc) : r_acc;
    assign w_mulExc  = ~((&w_mulProd[64:31]) | ~(|w_mulProd[64:31]));

    // Divide: remainder in the upper 33 bits, dividend shifts out as quotient shifts in
    assign w_divShift   = r_acc[63:31];
    assign w_divDiff    = {1'b0, w_divShift} - {2'b00, w_magB};
    assign w_divRem     = w_divDiff[33] ? w_divShift : w_divDiff[32:0];
    assign w_divNext    = {w_divRem, r_acc[30:0], ~w_divDiff[33]};
    assign w_quot       = w_neg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_divSpecial = (r_opB == 32'd0) ||
                          ((r_opA == 32'h8000_0000) && (r_opB == 32'hFFFF_FFFF));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A start pulse pre-empts whatever is in flight; multiply has priority
    always_comb begin
        w_next = r_state;
        if (bus.ctrl_MULT)     w_next = MUL;
        else if (bus.ctrl_DIV) w_next = DIV;
        else begin
            case (r_state)
                MUL, DIV: if (r_count == 6'd32) w_next = DONE;
                DONE:     w_next = IDLE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= 6'd0;
            r_opA       <= 32'd0;
            r_opB       <= 32'd0;
            r_acc       <= 65'd0;
            r_result    <= 32'd0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
        end else if (w_start) begin
            r_count <= 6'd0;
            r_opA   <= bus.data_operandA;
            r_opB   <= bus.data_operandB;
            r_acc   <= bus.ctrl_MULT ? {33'd0, mag32(bus.data_operandB)}
                                     : {33'd0, mag32(bus.data_operandA)};
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= w_lastIter;
            if (w_lastIter) begin
                if (r_state == MUL) begin
                    r_result    <= w_mulProd[31:0];
                    r_exception <= w_mulExc;
                end else if (w_divSpecial) begin
                    r_result    <= 32'd0;
                    r_exception <= 1'b1;
                end else begin
                    r_result    <= w_quot;
                    r_exception <= 1'b0;
                end
            end else if (r_state == MUL) begin
                r_acc   <= w_mulNext;
                r_count <= r_count + 6'd1;
            end else if (r_state == DIV) begin
                r_acc   <= w_divNext;
                r_count <= r_count + 6'd1;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: vector table plus scoreboard queue, followed
// by restart, priority, operand-hold and asynchronous-reset sequences.
module tb_multdiv;

    logic clock = 1'b0;
    logic reset;

    multdiv_if bus();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        bit          doMul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic        expExc;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Independent reference built on native signed arithmetic
    function automatic logic [32:0] modelOp(input bit doMul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint lim;
        int     q;
        lim = 64'sd2147483647;
        if (doMul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {((p > lim) || (p < -lim - 1)), p[31:0]};
        end
        if ((b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))
            return {1'b1, 32'd0};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    task automatic applyStimulus(input string name, input bit doMul, input bit doDiv,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic expExc, input bit track);
        exp_t e;
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = doMul;
        bus.ctrl_DIV      = doDiv;
        if (track) begin
            e.name = name;
            e.res  = expRes;
            e.exc  = expExc;
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    // Returns in the DONE cycle, 1 ns after the edge that raised RDY
    task automatic waitResult(input string name, input int expLat, input bit scramble);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.data_resultRDY) seen = 1'b1;
            else if (scramble) begin
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
        end
        checkOutput({name, ".latency"}, 32'(cyc), 32'(expLat));
        if (seen) begin
            if (sbQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL %s.unexpectedRdy: got RDY, expected none", name);
            end else begin
                e = sbQ.pop_front();
                checkOutput({e.name, ".result"}, bus.data_result, e.res);
                checkOutput({e.name, ".exception"}, 32'(bus.data_exception), 32'(e.exc));
            end
        end else if (sbQ.size() != 0) begin
            void'(sbQ.pop_front());
        end
    endtask

    task automatic watchNoRdy(input string name, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) pulses++;
        end
        checkOutput(name, 32'(pulses), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [32:0] m;

        vecs.push_back('{"mul7xm6",      1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0});
        vecs.push_back('{"mulOverflow",  1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{"mulMinx1",     1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{"mulMinxm1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"mulZero",      1'b1, 32'd0,          32'h1234_5678, 32'd0,         1'b0});
        vecs.push_back('{"mulm1xm1",     1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0});
        vecs.push_back('{"divm7by2",     1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"div7by0",      1'b0, 32'd7,          32'd0,         32'd0,         1'b1});
        vecs.push_back('{"divMinbym1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1});
        vecs.push_back('{"divMinby1",    1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{"div100by3",    1'b0, 32'd100,        32'd3,         32'd33,        1'b0});
        vecs.push_back('{"divm100bym3",  1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFFD, 32'd33,        1'b0});
        vecs.push_back('{"div5by7",      1'b0, 32'd5,          32'd7,         32'd0,         1'b0});
        vecs.push_back('{"divMaxbyMin",  1'b0, 32'h7FFF_FFFF,  32'h8000_0000, 32'd0,         1'b0});
        for (int i = 0; i < 6; i++) begin
            v.name  = $sformatf("rand%0d", i);
            v.doMul = (i % 2) == 0;
            v.a     = (i < 2) ? 32'($urandom_range(0, 65535)) : $urandom;
            v.b     = v.doMul ? $urandom : 32'($urandom_range(1, 5000));
            if (i == 5) v.b = 32'd0 - v.b;
            m = modelOp(v.doMul, v.a, v.b);
            v.expRes = m[31:0];
            v.expExc = m[32];
            vecs.push_back(v);
        end

        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        reset             = 1'b1;
        #1;
        checkOutput("reset.result", bus.data_result, 32'd0);
        checkOutput("reset.exception", 32'(bus.data_exception), 32'd0);
        checkOutput("reset.rdy", 32'(bus.data_resultRDY), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        watchNoRdy("idleNoRdy", 5);

        // Even entries wait for RDY to drop; odd ones issue during DONE
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].name, vecs[i].doMul, !vecs[i].doMul, vecs[i].a, vecs[i].b,
                          vecs[i].expRes, vecs[i].expExc, 1'b1);
            waitResult(vecs[i].name, 33, 1'b0);
            if ((i % 2) == 0) begin
                @(posedge clock);
                #1;
                checkOutput({vecs[i].name, ".rdyOneCycle"}, 32'(bus.data_resultRDY), 32'd0);
            end
        end

        // Abandoned divide: only the multiply may ever report
        applyStimulus("restartDiv", 1'b0, 1'b1, 32'd100, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        applyStimulus("restartMul", 1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b1);
        waitResult("restartMul", 33, 1'b0);
        watchNoRdy("restartSingleRdy", 40);

        applyStimulus("bothCtrl", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 1'b1);
        waitResult("bothCtrl", 33, 1'b0);
        @(posedge clock);

        applyStimulus("operandHold", 1'b0, 1'b1, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1);
        waitResult("operandHold", 33, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("hold%0d.result", i), bus.data_result, 32'd100);
            checkOutput($sformatf("hold%0d.exception", i), 32'(bus.data_exception), 32'd0);
            checkOutput($sformatf("hold%0d.rdy", i), 32'(bus.data_resultRDY), 32'd0);
        end

        // Asynchronous reset in the middle of iteration 15
        applyStimulus("resetVictim", 1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777, 32'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midReset.result", bus.data_result, 32'd0);
        checkOutput("midReset.exception", 32'(bus.data_exception), 32'd0);
        checkOutput("midReset.rdy", 32'(bus.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        watchNoRdy("postResetNoRdy", 50);
        applyStimulus("mul3x4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b1);
        waitResult("mul3x4", 33, 1'b0);

        checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
